// File: rtl/cu_next_state.sv
// ---------------------------------------------------------------------------
// cu_next_state
//   Sequential half of the multicycle RISC-V control unit. Holds the 4-bit
//   state register and advances it from the current state, the opcode held
//   in IR and memory readiness. It also reports instruction retirement, a
//   sticky illegal-opcode flag and the halted condition.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   opcode        IR[6:0]; meaningful from the decode state onward
//   mem_ready     memory completes the current access this cycle
//   StateRegister current state code (registered), feeds the Moore decoder
//   instr_done    one-cycle pulse in the cycle after an instruction retires
//   illegal_op    sticky flag, set when an unsupported opcode is seen
//   halted        high while the FSM sits in HALT (code 15)
//   instret       retired-instruction counter, wraps silently
// ---------------------------------------------------------------------------
module cu_next_state #(
   parameter int unsigned CNT_W           = 32,
   parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             mem_ready,
   output logic [3:0]       StateRegister,
   output logic             instr_done,
   output logic             illegal_op,
   output logic             halted,
   output logic [CNT_W-1:0] instret
);

   localparam int unsigned STATE_W = 4;
   localparam int unsigned OPC_W   = 7;

   // Base opcodes understood by the core
   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;

   // State codes are fixed: the Moore output decoder is keyed on them
   typedef enum logic [STATE_W-1:0] {
      sFetch    = 4'd0,
      sDecode   = 4'd1,
      sAddr     = 4'd2,
      sMemRead  = 4'd3,
      sLoadWb   = 4'd4,
      sMemWrite = 4'd5,
      sExecR    = 4'd6,
      sAluWb    = 4'd7,
      sBranch   = 4'd8,
      sLink     = 4'd9,
      sJal      = 4'd10,
      sUpper    = 4'd11,
      sJalr     = 4'd12,
      sExecI    = 4'd13,
      sUnused   = 4'd14,
      sHalt     = 4'd15
   } stateT;

   typedef enum logic [3:0] {
      clsLoad,
      clsStore,
      clsRtype,
      clsItype,
      clsBranch,
      clsJal,
      clsJalr,
      clsUpper,
      clsIllegal
   } opClassT;

   stateT   state;
   opClassT opClass;
   logic    retire;

   // Opcode classification
   always_comb begin
      opClass = clsIllegal;
      case (opcode)
         OPC_LOAD:          opClass = clsLoad;
         OPC_STORE:         opClass = clsStore;
         OPC_RTYPE:         opClass = clsRtype;
         OPC_ITYPE:         opClass = clsItype;
         OPC_BRANCH:        opClass = clsBranch;
         OPC_JAL:           opClass = clsJal;
         OPC_JALR:          opClass = clsJalr;
         OPC_AUIPC, OPC_LUI: opClass = clsUpper;
         default:           opClass = clsIllegal;
      endcase
   end

   // A transition is retiring when it closes an instruction's last state.
   // Returns to fetch from decode, address or the unused code do not retire.
   always_comb begin
      retire = 1'b0;
      case (state)
         sLoadWb, sAluWb, sBranch, sJal, sUpper, sJalr: retire = 1'b1;
         sMemWrite:                                     retire = mem_ready;
         default:                                       retire = 1'b0;
      endcase
   end

   // State register, retire bookkeeping and sticky illegal flag
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= sFetch;
         instr_done <= 1'b0;
         illegal_op <= 1'b0;
         instret    <= '0;
      end else begin
         instr_done <= retire;
         if (retire) begin
            instret <= instret + CNT_W'(1);
         end

         case (state)
            sFetch: begin
               if (mem_ready) state <= sDecode;
            end

            sDecode: begin
               case (opClass)
                  clsLoad, clsStore: state <= sAddr;
                  clsRtype:          state <= sExecR;
                  clsItype:          state <= sExecI;
                  clsBranch:         state <= sBranch;
                  clsJal, clsJalr:   state <= sLink;
                  clsUpper:          state <= sUpper;
                  default: begin
                     illegal_op <= 1'b1;
                     state      <= HALT_ON_ILLEGAL ? sHalt : sFetch;
                  end
               endcase
            end

            // IR should still hold a load/store here; anything else means
            // the instruction register was corrupted after decode.
            sAddr: begin
               if (opClass == clsLoad) begin
                  state <= sMemRead;
               end else if (opClass == clsStore) begin
                  state <= sMemWrite;
               end else begin
                  illegal_op <= 1'b1;
                  state      <= sFetch;
               end
            end

            sMemRead: begin
               if (mem_ready) state <= sLoadWb;
            end

            sMemWrite: begin
               if (mem_ready) state <= sFetch;
            end

            sExecR, sExecI: state <= sAluWb;

            // Same corrupted-IR treatment as the address state
            sLink: begin
               if (opClass == clsJal) begin
                  state <= sJal;
               end else if (opClass == clsJalr) begin
                  state <= sJalr;
               end else begin
                  illegal_op <= 1'b1;
                  state      <= sFetch;
               end
            end

            sLoadWb, sAluWb, sBranch, sJal, sUpper, sJalr, sUnused:
               state <= sFetch;

            // Only reset leaves HALT
            sHalt: state <= sHalt;

            default: state <= sFetch;
         endcase
      end
   end

   assign StateRegister = state;
   assign halted        = (state == sHalt);

endmodule

// File: doc/cu_next_state.md
Name: cu_next_state

Overview:
- Sequential half of the multicycle RISC-V control unit: holds the 4-bit state register and computes the next state from the current state, the instruction opcode and memory readiness.
- Its StateRegister output drives the Moore output decoder directly; that decoder raises no control signals for codes 14 and 15.
- Also provides retire and illegal-instruction status for the core and the debug logic.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 1, 1: an illegal opcode parks the FSM in HALT (15); 0: the FSM skips the instruction and returns to S0.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]; valid from S1 onward (IR is loaded in S0)
- mem_ready  in  1  memory completes the current access this cycle
- StateRegister  out  4  current state code, registered
- instr_done  out  1  one-cycle pulse, registered, in the cycle after the last state of an instruction
- illegal_op  out  1  sticky flag: an unsupported opcode was decoded
- halted  out  1  high while StateRegister==15
- instret  out  CNT_W  count of retired instructions

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: StateRegister=0, instr_done=0, illegal_op=0, halted=0, instret=0. Reset overrides all other activity, including reset mid-instruction and reset while in HALT.
- Opcode classes:
  - LOAD 0000011, STORE 0100011, RTYPE 0110011, ITYPE 0010011
  - BRANCH 1100011, JAL 1101111, JALR 1100111
  - AUIPC 0010111, LUI 0110111
  - Any other opcode is illegal.
- Transitions are evaluated at every rising edge. Memory wait states hold their current state until mem_ready=1:
  - S0 fetch: to S1 when mem_ready, else stay in S0.
  - S1 decode:
    - LOAD or STORE to S2
    - RTYPE to S6
    - ITYPE to S13
    - BRANCH to S8
    - JAL or JALR to S9
    - AUIPC or LUI to S11
    - illegal: set illegal_op; go to 15 if HALT_ON_ILLEGAL=1, else to S0.
  - S2 address: LOAD to S3; STORE to S5. Any other opcode here (IR corrupted) goes to S0 and sets illegal_op.
  - S3 memory read: to S4 when mem_ready, else stay in S3.
  - S4 to S0.
  - S5 memory write: to S0 when mem_ready, else stay in S5.
  - S6 to S7. S13 to S7. S7 to S0.
  - S8 to S0.
  - S9 link: JAL to S10; JALR to S12.
  - S10 to S0. S11 to S0. S12 to S0.
  - Code 14 (unused) to S0; does not set illegal_op and does not retire.
  - Code 15 HALT: stays in 15 until reset.
- Retire: a retiring transition is any transition into S0 from S4, S5 (with mem_ready), S7, S8, S10, S11 or S12.
  - On a retiring transition: instret increments by 1 on the same edge, and instr_done=1 for the following cycle.
  - Transitions into S0 from S1, S2 or 14 do not retire.
- instret wraps from all-ones to 0 with no flag.
- illegal_op clears only on reset.
- halted is derived combinationally from StateRegister==15.
- mem_ready is ignored outside S0, S3 and S5.
- Latency (mem_ready tied 1):
  - R/I-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - JAL/JALR: 4 cycles
  - AUIPC/LUI: 3 cycles
- Each mem_ready=0 cycle in S0, S3 or S5 adds one cycle to the instruction.

Test Plan:
- Reset, then opcode=0110011 with mem_ready=1 -> StateRegister sequence 0,1,6,7,0; instr_done high one cycle after re-entering S0; instret=1.
- opcode=0000011; mem_ready low 2 cycles in S0 and 3 cycles in S3 -> sequence 0,0,0,1,2,3,3,3,3,4,0; instret increments once.
- opcode=1100111 then 1101111 back-to-back -> sequences 0,1,9,12,0 and 0,1,9,10,0; instret=2.
- opcode=0000000 with HALT_ON_ILLEGAL=1 -> 0,1,15; illegal_op=1, halted=1, holds 20 cycles; reset then returns to S0 with all flags 0. Same stimulus with HALT_ON_ILLEGAL=0 -> 0,1,0; illegal_op=1; instret unchanged.
- Assert reset while in S3 with mem_ready=0 -> next cycle StateRegister=0, instret=0, instr_done=0.
- CNT_W=4: run 16 branches (opcode=1100011) -> instret reaches 15, then wraps to 0; each branch takes 3 cycles.
